mips_main_fsm: RTL and testbench

Multi-cycle main control state machine for the non-pipelined MIPS core. It sequences every instruction through fetch, decode, execute, memory and writeback states, and drives all datapath enables and mux selects. It is the producer of the 2-bit `ALUOp` consumed by `ALU_decoder`:

- 00 = add
- 01 = branch subtract
- 10 = R-type, decode funct
- 11 = I-type, decode op

---
 rtl/mips_main_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_mips_main_fsm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_main_fsm.sv
// mips_main_fsm
//
// Multi-cycle main control FSM for the non-pipelined MIPS core. Steps each
// instruction through fetch / decode / execute / memory / writeback and
// drives every datapath enable and mux select.
//
// Ports
//   clk        core clock
//   rst        synchronous, active-high reset
//   op         IR[31:26]; valid from DECODE until the next FETCH
//   funct      IR[5:0]
//   zero       ALU zero flag (combinational, current cycle)
//   ALUOp      00 add, 01 branch subtract, 10 R-type funct, 11 I-type op
//   ALUSrcA    00 PC, 01 reg A, 10 constant 0
//   ALUSrcB    00 reg B, 01 constant 4, 10 ext imm, 11 sext imm << 2
//   ImmSel     00 sign-extend, 01 zero-extend, 10 imm << 16
//   PCSrc      00 ALUResult, 01 ALUOut, 10 jump target, 11 reg A
//   IorD       memory address: 0 PC, 1 ALUOut
//   IRWrite, MemWrite, RegWrite, PCWrite   write enables
//   PCEn       final PC enable (PCWrite or taken branch)
//   RegDst     0 rt, 1 rd
//   MemtoReg   0 ALUOut, 1 data register
//   IllegalOp  one-cycle pulse in DECODE of an unsupported opcode
//   State      current state encoding (debug)

module mips_main_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSel,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       PCEn,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } mips_op_e;

  typedef enum logic [5:0] {
    FN_JR = 6'b001000
  } mips_funct_e;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12
  } state_e;

  state_e state;
  state_e state_nxt;

  // Raw (ungated) enables; reset masks them below.
  logic irwrite_raw;
  logic memwrite_raw;
  logic regwrite_raw;
  logic pcwrite_raw;
  logic illegal_raw;
  logic branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. op/funct only matter in DECODE and MEMADR.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                     state_nxt = S_MEMADR;
          OP_RTYPE:                         state_nxt = (funct == FN_JR) ? S_JR : S_EXECUTE;
          OP_BEQ, OP_BNE:                   state_nxt = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_nxt = S_IEXEC;
          OP_J:                             state_nxt = S_JUMP;
          default:                          state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_nxt = S_MEMRD;
        end else if (op == OP_SW) begin
          state_nxt = S_MEMWR;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_MEMRD:   state_nxt = S_MEMWB;
      S_MEMWB:   state_nxt = S_FETCH;
      S_MEMWR:   state_nxt = S_FETCH;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_ALUWB:   state_nxt = S_FETCH;
      S_BRANCH:  state_nxt = S_FETCH;
      S_IEXEC:   state_nxt = S_IWB;
      S_IWB:     state_nxt = S_FETCH;
      S_JUMP:    state_nxt = S_FETCH;
      S_JR:      state_nxt = S_FETCH;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Output decode. Moore on state, except the IEXEC operand selects which
  // follow the live opcode.
  always_comb begin
    ALUOp        = '0;
    ALUSrcA      = '0;
    ALUSrcB      = '0;
    ImmSel       = '0;
    PCSrc        = '0;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite_raw  = 1'b0;
    illegal_raw  = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite_raw = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_J: illegal_raw = 1'b0;
          default:                                illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        IorD         = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegDst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b01;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
      end
      S_IEXEC: begin
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        case (op)
          OP_ADDI: begin
            ALUSrcA = 2'b01;
            ImmSel  = 2'b00;
          end
          OP_ANDI, OP_ORI: begin
            ALUSrcA = 2'b01;
            ImmSel  = 2'b01;
          end
          OP_LUI: begin
            ALUSrcA = 2'b10;
            ImmSel  = 2'b10;
          end
          default: begin
            ALUSrcA = 2'b00;
            ImmSel  = 2'b00;
          end
        endcase
      end
      S_IWB: begin
        regwrite_raw = 1'b1;
      end
      S_JUMP: begin
        PCSrc       = 2'b10;
        pcwrite_raw = 1'b1;
      end
      S_JR: begin
        PCSrc       = 2'b11;
        pcwrite_raw = 1'b1;
      end
      default: begin
        ALUOp = '0;
      end
    endcase
  end

  // BEQ takes on zero, anything else in BRANCH (BNE) takes on not-zero.
  assign branch_taken = (state == S_BRANCH) && ((op == OP_BEQ) ? zero : ~zero);

  assign IRWrite   = irwrite_raw  & ~rst;
  assign MemWrite  = memwrite_raw & ~rst;
  assign RegWrite  = regwrite_raw & ~rst;
  assign PCWrite   = pcwrite_raw  & ~rst;
  assign IllegalOp = illegal_raw  & ~rst;
  assign PCEn      = (pcwrite_raw | branch_taken) & ~rst;
  assign State     = state;

endmodule

// File: tb/tb_mips_main_fsm.sv
// Directed bench for mips_main_fsm: the stimulus process pushes the expected
// output vector for each cycle; a monitor on the falling edge pops and
// compares it against the DUT outputs.

module tb_mips_main_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] pcsrc;
    logic       iord;
    logic       irw;
    logic       memw;
    logic       regw;
    logic       pcw;
    logic       pcen;
    logic       regdst;
    logic       m2r;
    logic       ill;
  } vec_t;

  //                                  st    aluop  srca   srcb   imm    pcsrc  iord irw memw regw pcw pcen rdst m2r ill
  localparam vec_t V_FETCH     = '{4'd0,  2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
  localparam vec_t V_DECODE    = '{4'd1,  2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_DECODE_IL = '{4'd1,  2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam vec_t V_MEMADR    = '{4'd2,  2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_MEMRD     = '{4'd3,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_MEMWB     = '{4'd4,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam vec_t V_MEMWR     = '{4'd5,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_EXECUTE   = '{4'd6,  2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_ALUWB     = '{4'd7,  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam vec_t V_BR_TAKEN  = '{4'd8,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
  localparam vec_t V_BR_NOT    = '{4'd8,  2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_IEX_ADDI  = '{4'd9,  2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_IEX_LOGIC = '{4'd9,  2'b11, 2'b01, 2'b10, 2'b01, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_IEX_LUI   = '{4'd9,  2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_IWB       = '{4'd10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam vec_t V_JUMP      = '{4'd11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};
  localparam vec_t V_JR        = '{4'd12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ImmSel, PCSrc;
  logic       IorD, IRWrite, MemWrite, RegWrite, PCWrite, PCEn;
  logic       RegDst, MemtoReg, IllegalOp;
  logic [3:0] State;

  mips_main_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .ALUOp     (ALUOp),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSel    (ImmSel),
    .PCSrc     (PCSrc),
    .IorD      (IorD),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .PCWrite   (PCWrite),
    .PCEn      (PCEn),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  // Reset forces every write enable and the illegal pulse low.
  function automatic vec_t rst_mask(input vec_t v);
    vec_t r;
    r      = v;
    r.irw  = 1'b0;
    r.memw = 1'b0;
    r.regw = 1'b0;
    r.pcw  = 1'b0;
    r.pcen = 1'b0;
    r.ill  = 1'b0;
    return r;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs for it.
  task automatic cyc(input string nm, input vec_t e, input logic r,
                     input logic [5:0] o, input logic [5:0] f, input logic z);
    rst   = r;
    op    = o;
    funct = f;
    zero  = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every falling edge with a pending expectation is compared.
  initial begin
    vec_t  act;
    vec_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        act = '{State, ALUOp, ALUSrcA, ALUSrcB, ImmSel, PCSrc, IorD, IRWrite,
                MemWrite, RegWrite, PCWrite, PCEn, RegDst, MemtoReg, IllegalOp};
        n_vec++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                   nm, act, e, act.st, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    op    = 6'b111111;
    funct = '0;
    zero  = 1'b0;
    @(posedge clk);
    #1;

    // Reset state: FETCH selects, enables masked.
    cyc("reset_fetch", rst_mask(V_FETCH), 1'b1, 6'b111111, 6'h00, 1'b0);

    // LW; op is garbage during FETCH and must not matter.
    cyc("lw_fetch",  V_FETCH,  1'b0, 6'b111111, 6'h00, 1'b0);
    cyc("lw_decode", V_DECODE, 1'b0, 6'b100011, 6'h00, 1'b0);
    cyc("lw_memadr", V_MEMADR, 1'b0, 6'b100011, 6'h00, 1'b0);
    cyc("lw_memrd",  V_MEMRD,  1'b0, 6'b100011, 6'h00, 1'b0);
    cyc("lw_memwb",  V_MEMWB,  1'b0, 6'b100011, 6'h00, 1'b0);

    // R-type ADD; funct flips during EXECUTE with no effect.
    cyc("add_fetch",   V_FETCH,   1'b0, 6'b000000, 6'h20, 1'b0);
    cyc("add_decode",  V_DECODE,  1'b0, 6'b000000, 6'h20, 1'b0);
    cyc("add_execute", V_EXECUTE, 1'b0, 6'b000000, 6'h08, 1'b0);
    cyc("add_aluwb",   V_ALUWB,   1'b0, 6'b000000, 6'h08, 1'b0);

    // R-type JR.
    cyc("jr_fetch",  V_FETCH,  1'b0, 6'b000000, 6'h08, 1'b0);
    cyc("jr_decode", V_DECODE, 1'b0, 6'b000000, 6'h08, 1'b0);
    cyc("jr_jr",     V_JR,     1'b0, 6'b000000, 6'h08, 1'b0);

    // Branches: taken/not-taken per op and same-cycle zero.
    cyc("beq1_fetch",  V_FETCH,    1'b0, 6'b000100, 6'h00, 1'b0);
    cyc("beq1_decode", V_DECODE,   1'b0, 6'b000100, 6'h00, 1'b0);
    cyc("beq1_branch", V_BR_TAKEN, 1'b0, 6'b000100, 6'h00, 1'b1);
    cyc("beq0_fetch",  V_FETCH,    1'b0, 6'b000100, 6'h00, 1'b1);
    cyc("beq0_decode", V_DECODE,   1'b0, 6'b000100, 6'h00, 1'b1);
    cyc("beq0_branch", V_BR_NOT,   1'b0, 6'b000100, 6'h00, 1'b0);
    cyc("bne1_fetch",  V_FETCH,    1'b0, 6'b000101, 6'h00, 1'b0);
    cyc("bne1_decode", V_DECODE,   1'b0, 6'b000101, 6'h00, 1'b0);
    cyc("bne1_branch", V_BR_NOT,   1'b0, 6'b000101, 6'h00, 1'b1);
    cyc("bne0_fetch",  V_FETCH,    1'b0, 6'b000101, 6'h00, 1'b1);
    cyc("bne0_decode", V_DECODE,   1'b0, 6'b000101, 6'h00, 1'b1);
    cyc("bne0_branch", V_BR_TAKEN, 1'b0, 6'b000101, 6'h00, 1'b0);

    // I-type ops.
    cyc("lui_fetch",   V_FETCH,     1'b0, 6'b001111, 6'h00, 1'b0);
    cyc("lui_decode",  V_DECODE,    1'b0, 6'b001111, 6'h00, 1'b0);
    cyc("lui_iexec",   V_IEX_LUI,   1'b0, 6'b001111, 6'h00, 1'b0);
    cyc("lui_iwb",     V_IWB,       1'b0, 6'b001111, 6'h00, 1'b0);
    cyc("ori_fetch",   V_FETCH,     1'b0, 6'b001101, 6'h00, 1'b0);
    cyc("ori_decode",  V_DECODE,    1'b0, 6'b001101, 6'h00, 1'b0);
    cyc("ori_iexec",   V_IEX_LOGIC, 1'b0, 6'b001101, 6'h00, 1'b0);
    cyc("ori_iwb",     V_IWB,       1'b0, 6'b001101, 6'h00, 1'b0);
    cyc("andi_fetch",  V_FETCH,     1'b0, 6'b001100, 6'h00, 1'b0);
    cyc("andi_decode", V_DECODE,    1'b0, 6'b001100, 6'h00, 1'b0);
    cyc("andi_iexec",  V_IEX_LOGIC, 1'b0, 6'b001100, 6'h00, 1'b0);
    cyc("andi_iwb",    V_IWB,       1'b0, 6'b001100, 6'h00, 1'b0);
    cyc("addi_fetch",  V_FETCH,     1'b0, 6'b001000, 6'h00, 1'b0);
    cyc("addi_decode", V_DECODE,    1'b0, 6'b001000, 6'h00, 1'b0);
    cyc("addi_iexec",  V_IEX_ADDI,  1'b0, 6'b001000, 6'h00, 1'b0);
    cyc("addi_iwb",    V_IWB,       1'b0, 6'b001000, 6'h00, 1'b0);

    // J.
    cyc("j_fetch",  V_FETCH,  1'b0, 6'b000010, 6'h00, 1'b0);
    cyc("j_decode", V_DECODE, 1'b0, 6'b000010, 6'h00, 1'b0);
    cyc("j_jump",   V_JUMP,   1'b0, 6'b000010, 6'h00, 1'b0);

    // SW aborted by reset in MEMWR; held one more cycle, then released.
    cyc("sw_fetch",      V_FETCH,            1'b0, 6'b101011, 6'h00, 1'b0);
    cyc("sw_decode",     V_DECODE,           1'b0, 6'b101011, 6'h00, 1'b0);
    cyc("sw_memadr",     V_MEMADR,           1'b0, 6'b101011, 6'h00, 1'b0);
    cyc("sw_memwr_rst",  rst_mask(V_MEMWR),  1'b1, 6'b101011, 6'h00, 1'b0);
    cyc("sw_fetch_rst",  rst_mask(V_FETCH),  1'b1, 6'b101011, 6'h00, 1'b0);
    cyc("sw_fetch_post", V_FETCH,            1'b0, 6'b101011, 6'h00, 1'b0);

    // Illegal op: pulse in DECODE, then straight back to FETCH.
    cyc("ill_decode", V_DECODE_IL, 1'b0, 6'b111111, 6'h00, 1'b0);
    cyc("ill_fetch",  V_FETCH,     1'b0, 6'b111111, 6'h00, 1'b0);
    cyc("ill_decode2", V_DECODE,   1'b0, 6'b000010, 6'h00, 1'b0);
    cyc("ill_jump",   V_JUMP,      1'b0, 6'b000010, 6'h00, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
